// File: rtl/branch_resolve_ctrl.sv
// Multicycle branch-resolution controller for the MIPS decode stage: waits for operands,
// evaluates the branch condition and emits a one-cycle decision. Optional stats: BR_STAT_EN.
module branch_resolve_ctrl #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_req,
  input  logic [2:0]            br_op,
  input  logic [31:0]           br_pc,
  input  logic [15:0]           br_off,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           rt_val,
  input  logic                  rs_rdy,
  input  logic                  rt_rdy,
  input  logic                  flush,
  output logic                  stall,
  output logic                  dec_valid,
  output logic                  dec_taken,
  output logic [31:0]           dec_target,
  output logic [WAIT_CNT_W-1:0] wait_cnt
`ifdef BR_STAT_EN
  ,
  output logic [31:0]           br_total,
  output logic [31:0]           br_taken
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLEZ = 3'd2,
    OP_BGTZ = 3'd3,
    OP_BLTZ = 3'd4,
    OP_BGEZ = 3'd5
  } br_op_t;

  state_t      state, next_state;
  logic        ready;
  logic        capture;
  logic        wait_clr;
  logic        taken_eval;
  logic [31:0] target_eval;

  logic [2:0]  cap_op;
  logic [31:0] cap_rs;
  logic [31:0] cap_rt;
  logic [31:0] cap_pc;
  logic [15:0] cap_off;

  // Only beq/bne read rt; every other op resolves on rs alone.
  assign ready = rs_rdy && (rt_rdy || br_op >= 3'd2);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_req) begin
          if (ready) begin
            capture    = 1'b1;
            next_state = ST_EVAL;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!br_req) begin
          next_state = ST_IDLE;
        end else if (ready) begin
          capture    = 1'b1;
          next_state = ST_EVAL;
        end
      end
      ST_EVAL: next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    if (flush) begin
      next_state = ST_IDLE;
      capture    = 1'b0;
    end
  end

  assign wait_clr  = (state == ST_IDLE) && (next_state == ST_WAIT);
  assign stall     = br_req && (state != ST_RESP);
  assign dec_valid = (state == ST_RESP) && !flush;

  always_comb begin
    taken_eval = 1'b0;
    case (cap_op)
      OP_BEQ:  taken_eval = (cap_rs == cap_rt);
      OP_BNE:  taken_eval = (cap_rs != cap_rt);
      OP_BLEZ: taken_eval = cap_rs[31] || (cap_rs == 32'd0);
      OP_BGTZ: taken_eval = !cap_rs[31] && (cap_rs != 32'd0);
      OP_BLTZ: taken_eval = cap_rs[31];
      OP_BGEZ: taken_eval = !cap_rs[31];
      default: taken_eval = 1'b0;
    endcase
  end

  // Taken target is relative to the delay slot; not-taken skips the delay slot.
  assign target_eval = taken_eval
                     ? cap_pc + 32'd4 + {{14{cap_off[15]}}, cap_off, 2'b00}
                     : cap_pc + 32'd8;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dec_taken  <= 1'b0;
      dec_target <= 32'd0;
      wait_cnt   <= '0;
    end else begin
      state <= next_state;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end
      if (state == ST_EVAL && !flush) begin
        dec_taken  <= taken_eval;
        dec_target <= target_eval;
      end
    end
  end

  // NOTE: the capture registers carry no reset; they are always loaded before EVAL reads them.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_op  <= br_op;
      cap_rs  <= rs_val;
      cap_rt  <= rt_val;
      cap_pc  <= br_pc;
      cap_off <= br_off;
    end
  end

`ifdef BR_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_total <= 32'd0;
      br_taken <= 32'd0;
    end else if (dec_valid) begin
      br_total <= br_total + 32'd1;
      if (dec_taken) br_taken <= br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl against a transaction-level model.
// Build with BR_STAT_EN defined to also check the statistics counters.
module tb_branch_resolve_ctrl;

  localparam int W = 8;
  localparam int SAT = (1 << W) - 1;

  logic          clk;
  logic          reset;
  logic          br_req;
  logic [2:0]    br_op;
  logic [31:0]   br_pc;
  logic [15:0]   br_off;
  logic [31:0]   rs_val;
  logic [31:0]   rt_val;
  logic          rs_rdy;
  logic          rt_rdy;
  logic          flush;
  logic          stall;
  logic          dec_valid;
  logic          dec_taken;
  logic [31:0]   dec_target;
  logic [W-1:0]  wait_cnt;
`ifdef BR_STAT_EN
  logic [31:0]   br_total;
  logic [31:0]   br_taken;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int unsigned m_wait  = 0;
  int unsigned m_total = 0;
  int unsigned m_taken = 0;

  branch_resolve_ctrl #(.WAIT_CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .br_req     (br_req),
    .br_op      (br_op),
    .br_pc      (br_pc),
    .br_off     (br_off),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .rs_rdy     (rs_rdy),
    .rt_rdy     (rt_rdy),
    .flush      (flush),
    .stall      (stall),
    .dec_valid  (dec_valid),
    .dec_taken  (dec_taken),
    .dec_target (dec_target),
    .wait_cnt   (wait_cnt)
`ifdef BR_STAT_EN
    ,
    .br_total   (br_total),
    .br_taken   (br_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) <= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) < 0;
      3'd5:    return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off, input bit taken);
    int woff;
    woff = int'($signed(off));
    return taken ? pc + 32'(4 + 4 * woff) : pc + 32'd8;
  endfunction

  task automatic scramble_vals();
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic scramble_all();
    scramble_vals();
    br_op  = 3'($urandom);
    br_pc  = $urandom;
    br_off = 16'($urandom);
    rs_rdy = 1'($urandom);
    rt_rdy = 1'($urandom);
  endtask

  // One branch held by decode: h cycles of missing operand, then resolution and an idle cycle.
  task automatic run_branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] pc, input logic [15:0] off, input int h, input bit rt_haz);
    bit          exp_t;
    logic [31:0] exp_pc;
    exp_t  = ref_taken(op, rs, rt);
    exp_pc = ref_target(pc, off, exp_t);
    if (h > 0) m_wait = (h > SAT) ? SAT : h;
    for (int k = 0; k <= h + 2; k++) begin
      @(negedge clk);
      br_req = 1'b1;
      flush  = 1'b0;
      if (k < h) begin
        br_op = op; br_pc = pc; br_off = off;
        scramble_vals();
        if (op < 3'd2 && rt_haz) begin
          rs_rdy = 1'b1; rt_rdy = 1'b0;
        end else begin
          rs_rdy = 1'b0; rt_rdy = 1'($urandom);
        end
      end else if (k == h) begin
        br_op = op; br_pc = pc; br_off = off;
        rs_val = rs; rt_val = rt;
        rs_rdy = 1'b1;
        rt_rdy = (op < 3'd2) ? 1'b1 : 1'($urandom);
      end else begin
        scramble_all();
      end
      #2;
      check("stall", 32'(stall), 32'(k < h + 2));
      check("dec_valid", 32'(dec_valid), 32'(k == h + 2));
      if (k == h + 2) begin
        check("dec_taken", 32'(dec_taken), 32'(exp_t));
        check("dec_target", dec_target, exp_pc);
        check("wait_cnt", 32'(wait_cnt), m_wait);
        m_total++;
        if (exp_t) m_taken++;
      end
    end
    @(negedge clk);
    br_req = 1'b0;
    scramble_all();
    #2;
    check("idle_dec_valid", 32'(dec_valid), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
  endtask

  // Ready branch cancelled by flush in EVAL (in_resp=0) or in RESP (in_resp=1).
  task automatic flush_branch(input bit in_resp);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        br_req = 1'b1; br_op = 3'd0; br_pc = $urandom; br_off = 16'($urandom);
        rs_val = 32'd1; rt_val = 32'd1; rs_rdy = 1'b1; rt_rdy = 1'b1;
      end else begin
        scramble_all();
        br_req = (k == 1);
      end
      flush = (k == 1 && !in_resp) || (k == 2 && in_resp);
      #2;
      check("flush_dec_valid", 32'(dec_valid), 32'd0);
      if (k <= 1) check("flush_stall", 32'(stall), 32'd1);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; br_req = 1'b1; flush = 1'b0;
    br_op = 3'd0; br_pc = 32'd0; br_off = 16'd0;
    rs_val = 32'd0; rt_val = 32'd0; rs_rdy = 1'b0; rt_rdy = 1'b0;
    #7;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_taken", 32'(dec_taken), 32'd0);
    check("rst_dec_target", dec_target, 32'd0);
    check("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    @(negedge clk);
    br_req = 1'b0;
    reset  = 1'b1;

    // Directed cases from the branch-resolution scenarios.
    run_branch(3'd0, 32'd5, 32'd5, 32'h3000, 16'h0004, 0, 1'b0);
    run_branch(3'd1, 32'd7, 32'd7, 32'h4000, 16'h0010, 3, 1'b1);
    run_branch(3'd2, 32'd0, 32'd9, 32'h3000, 16'h0020, 0, 1'b0);
    run_branch(3'd3, 32'd0, 32'd9, 32'h3000, 16'h0020, 1, 1'b0);
    run_branch(3'd5, 32'd0, 32'd9, 32'h3000, 16'h0020, 0, 1'b0);
    run_branch(3'd4, 32'd0, 32'd9, 32'h3000, 16'h0020, 2, 1'b0);
    run_branch(3'd4, 32'h8000_0000, 32'd0, 32'h3000, 16'h0008, 0, 1'b0);
    run_branch(3'd2, 32'h8000_0000, 32'd0, 32'h3000, 16'h0008, 0, 1'b0);
    run_branch(3'd5, 32'h8000_0000, 32'd0, 32'h3000, 16'h0008, 0, 1'b0);
    run_branch(3'd4, 32'hFFFF_FFFF, 32'd0, 32'h3000, 16'hFFFF, 0, 1'b0);
    run_branch(3'd6, 32'hFFFF_FFFF, 32'd0, 32'h3000, 16'h0001, 0, 1'b0);
    run_branch(3'd7, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0001, 1, 1'b0);
    run_branch(3'd0, 32'd3, 32'd3, 32'hFFFF_FFF0, 16'h7FFF, 300, 1'b1);

    flush_branch(1'b0);
    run_branch(3'd0, 32'd11, 32'd11, 32'h5000, 16'h0100, 0, 1'b0);
    flush_branch(1'b1);
    run_branch(3'd1, 32'd11, 32'd12, 32'h5000, 16'hFF00, 0, 1'b0);

    // Reset in WAIT once wait_cnt has reached 2.
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      br_req = 1'b1; br_op = 3'd0; rs_rdy = 1'b1; rt_rdy = 1'b0;
      scramble_vals();
    end
    #2;
    check("pre_rst_wait_cnt", 32'(wait_cnt), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd1);
    check("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_dec_taken", 32'(dec_taken), 32'd0);
    check("mid_rst_dec_target", dec_target, 32'd0);
    check("mid_rst_wait_cnt", 32'(wait_cnt), 32'd0);
    m_wait = 0; m_total = 0; m_taken = 0;
    @(negedge clk);
    br_req = 1'b0;
    reset  = 1'b1;

    run_branch(3'd0, 32'd5, 32'd5, 32'h3000, 16'h0004, 0, 1'b0);
    run_branch(3'd1, 32'd7, 32'd7, 32'h3000, 16'h0004, 0, 1'b0);
`ifdef BR_STAT_EN
    check("br_total_two", br_total, 32'd2);
    check("br_taken_two", br_taken, 32'd1);
`endif

    // Randomized transactions with occasional flushed branches.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          h;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       rs = 32'd0;
        1:       rs = 32'h8000_0000;
        2:       rs = 32'($urandom_range(0, 3));
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      h  = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 6);
      if ($urandom_range(0, 14) == 0) flush_branch(1'($urandom));
      run_branch(op, rs, rt, $urandom, 16'($urandom), h, 1'($urandom));
    end

`ifdef BR_STAT_EN
    check("br_total_final", br_total, m_total);
    check("br_taken_final", br_taken, m_taken);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
